mcu_bus_tx: RTL and testbench

- Transmit side of the 8-bit parallel MCU bus: the GPU drives bytes back to the MCU, for example status, read-back data and interrupt reasons.
- Sits beside the existing bus receiver on the same pins.
- Takes bytes from internal logic over a valid/ready handshake, then requests and holds bus ownership.
- Generates its own strobe clock and command/data flag, and releases the bus after a turnaround gap.

---
 rtl/msgpu_pkg.sv | 28 ++
 rtl/mcu_bus_tx_fifo.sv | 52 +++++
 rtl/mcu_bus_tx.sv | 128 ++++++++++++
 tb/tb_mcu_bus_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msgpu_pkg.sv
// rtl/msgpu_pkg.sv - shared MCU bus types, constants and helpers
package msgpu_pkg;

    localparam int MCU_BUS_WIDTH = 8;

    // Command/data flag encoding shared with the bus receiver
    localparam logic CMD  = 1'b1;
    localparam logic DATA = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        TURN_ON,
        SETUP,
        STROBE,
        HOLD,
        TURN_OFF
    } tx_state_t;

    typedef struct packed {
        logic                     command;
        logic [MCU_BUS_WIDTH-1:0] data;
    } tx_entry_t;

    function automatic logic is_turn(tx_state_t s);
        return (s == TURN_ON) || (s == TURN_OFF);
    endfunction

endpackage

// File: rtl/mcu_bus_tx_fifo.sv
// rtl/mcu_bus_tx_fifo.sv - synchronous FIFO with wrap-bit pointers for the MCU bus transmitter
module mcu_bus_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      used;
    logic             do_push;
    logic             do_pop;

    // The extra top bit distinguishes full from empty when the indices match
    assign used    = wptr - rptr;
    assign full    = (used == (AW+1)'(DEPTH));
    assign empty   = (used == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mcu_bus_tx.sv
// rtl/mcu_bus_tx.sv - MCU parallel bus transmitter; MCU_BUS_TX_FIFO_EN selects an input FIFO over a holding register
module mcu_bus_tx
    import msgpu_pkg::*;
#(
    parameter int PHASE_CYCLES = 2,
    parameter int TURN_CYCLES  = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [MCU_BUS_WIDTH-1:0] tx_data,
    input  logic                     tx_command,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic                     bus_grant,
    output logic [MCU_BUS_WIDTH-1:0] bus_out,
    output logic                     bus_oe,
    output logic                     busclk_out,
    output logic                     command_data_out,
    output logic                     busy,
    output logic                     byte_sent,
    output logic [15:0]              tx_count
);
    tx_state_t state;
    tx_state_t next_state;
    logic [3:0] cnt;
    logic       cnt_last;
    logic       pending;
    logic       load_setup;
    logic       load_head;
    logic       byte_done;
    tx_entry_t  head;

    if (PHASE_CYCLES < 1 || PHASE_CYCLES > 15 || TURN_CYCLES < 1 || TURN_CYCLES > 15 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("mcu_bus_tx: parameter out of legal range");
    end

`ifdef MCU_BUS_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    mcu_bus_tx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(tx_entry_t))
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (tx_valid && !fifo_full),
        .wdata({tx_command, tx_data}),
        .pop  (load_setup),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign tx_ready = !fifo_full;
    assign pending  = !fifo_empty;
`else
    tx_entry_t hold_q;
    logic      hold_full;

    // Push needs an empty register and pop needs a full one, so they never coincide
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_q    <= '0;
        end else if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_q    <= {tx_command, tx_data};
        end else if (load_setup) begin
            hold_full <= 1'b0;
        end
    end

    assign tx_ready = !hold_full;
    assign pending  = hold_full;
    assign head     = hold_q;
`endif

    assign cnt_last = is_turn(state) ? (cnt == 4'(TURN_CYCLES - 1))
                                     : (cnt == 4'(PHASE_CYCLES - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (pending && bus_grant) next_state = TURN_ON;
            TURN_ON:  if (cnt_last) next_state = SETUP;
            SETUP:    if (cnt_last) next_state = STROBE;
            STROBE:   if (cnt_last) next_state = HOLD;
            HOLD:     if (cnt_last) next_state = (pending && bus_grant) ? SETUP : TURN_OFF;
            TURN_OFF: if (cnt_last) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    assign load_setup = (next_state == SETUP) && (state != SETUP);
    assign load_head  = load_setup || ((state == IDLE) && (next_state == TURN_ON));
    assign byte_done  = (state == HOLD) && cnt_last;
    assign busy       = (state != IDLE);
    assign byte_sent  = byte_done;

    // Bus-facing outputs are registered from next_state so the strobe is glitch-free
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            bus_oe           <= 1'b0;
            busclk_out       <= 1'b0;
            bus_out          <= '0;
            command_data_out <= DATA;
            tx_count         <= '0;
        end else begin
            state      <= next_state;
            cnt        <= (next_state != state) ? 4'd0 : cnt + 4'd1;
            bus_oe     <= (next_state != IDLE);
            busclk_out <= (next_state == STROBE);
            if (load_head) begin
                bus_out          <= head.data;
                command_data_out <= head.command;
            end
            if (byte_done) begin
                tx_count <= tx_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mcu_bus_tx.sv
// tb/tb_mcu_bus_tx.sv - self-checking bench for mcu_bus_tx against a timeline model
module tb_mcu_bus_tx;
    localparam int P  = 2;
    localparam int T  = 2;
    localparam int HN = 4096;
`ifdef MCU_BUS_TX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_command = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        bus_grant = 1'b0;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic        busclk_out;
    logic        command_data_out;
    logic        busy;
    logic        byte_sent;
    logic [15:0] tx_count;

    mcu_bus_tx dut (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_command(tx_command),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_grant(bus_grant), .bus_out(bus_out),
        .bus_oe(bus_oe), .busclk_out(busclk_out), .command_data_out(command_data_out),
        .busy(busy), .byte_sent(byte_sent), .tx_count(tx_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_push = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc = cyc + 1;

    // Timeline model: session = TURN lead, 3*P cycles per byte, TURN trail
    logic [8:0]  mq[$];
    int          m_ph = 0;
    int          m_k = 0;
    logic [8:0]  m_cur = '0;
    logic [15:0] m_count = '0;
    logic        push_ok;

    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            m_ph = 0; m_k = 0; m_cur = '0; m_count = '0;
        end else begin
            push_ok = tx_valid && (mq.size() < CAP);
            case (m_ph)
                0: if (mq.size() > 0 && bus_grant) begin m_ph = 1; m_k = 0; m_cur = mq[0]; end
                1: begin
                    m_k++;
                    if (m_k == T) begin m_ph = 2; m_k = 0; m_cur = mq.pop_front(); end
                end
                2: if (m_k == 3*P-1) begin
                    m_count = m_count + 16'd1;
                    if (mq.size() > 0 && bus_grant) begin m_k = 0; m_cur = mq.pop_front(); end
                    else begin m_ph = 3; m_k = 0; end
                end else m_k++;
                3: begin
                    m_k++;
                    if (m_k == T) begin m_ph = 0; m_k = 0; end
                end
                default: ;
            endcase
            if (push_ok) mq.push_back({tx_command, tx_data});
        end
    end

    logic       h_oe  [HN];
    logic       h_clk [HN];
    logic       h_sent[HN];
    logic       h_cmd [HN];
    logic [7:0] h_bus [HN];

    always @(negedge clock) begin
        if (cyc < HN) begin
            h_oe[cyc] = bus_oe; h_clk[cyc] = busclk_out; h_sent[cyc] = byte_sent;
            h_cmd[cyc] = command_data_out; h_bus[cyc] = bus_out;
        end
        if (chk_en) begin
            check("bus_oe", bus_oe, int'(m_ph != 0));
            check("busy", busy, int'(m_ph != 0));
            check("busclk_out", busclk_out, int'(m_ph == 2 && m_k >= P && m_k < 2*P));
            check("byte_sent", byte_sent, int'(m_ph == 2 && m_k == 3*P-1));
            check("bus_out", bus_out, m_cur[7:0]);
            check("command_data_out", command_data_out, m_cur[8]);
            check("tx_count", tx_count, m_count);
            check("tx_ready", tx_ready, int'(mq.size() < CAP));
        end
    end

    function automatic int first_oe(int from, int to);
        for (int i = from; i <= to; i++) if (h_oe[i]) return i;
        return -1;
    endfunction

    function automatic int last_oe(int from, int to);
        int r = -1;
        for (int i = from; i <= to; i++) if (h_oe[i]) r = i;
        return r;
    endfunction

    function automatic int count_sig(int from, int to, int which);
        int n = 0;
        for (int i = from; i <= to; i++)
            n += (which == 0) ? int'(h_oe[i]) : (which == 1) ? int'(h_clk[i]) : int'(h_sent[i]);
        return n;
    endfunction

    function automatic int rise_clk(int from, int to, int nth);
        int n = 0;
        for (int i = from + 1; i <= to; i++)
            if (h_clk[i] && !h_clk[i-1]) begin n++; if (n == nth) return i; end
        return -1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic cmd, input logic [7:0] d);
        int n = 0;
        tx_valid = 1'b1; tx_command = cmd; tx_data = d;
        while (!tx_ready && n < 200) begin step(); n++; end
        if (!tx_ready) check("push_timeout", 0, 1);
        else begin step(); last_push = cyc; end
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) step();
        while ((busy || bus_oe) && n < 300) begin step(); n++; end
        check("idle_timeout", int'(busy || bus_oe), 0);
    endtask

    task automatic wait_strobe();
        int n = 0;
        while (!busclk_out && n < 60) begin step(); n++; end
        check("strobe_timeout", busclk_out, 1);
    endtask

    int t0, a, s, r1, r2, r3, r4;
    logic [15:0] c0;

    initial begin
        repeat (3) step();
        chk_en = 1'b1;
        check("rst_bus_oe", bus_oe, 0);
        check("rst_bus_out", bus_out, 8'h00);
        check("rst_tx_count", tx_count, 0);
        check("rst_tx_ready", tx_ready, 1);
        reset = 1'b0;
        step();

        // Single byte with hand-computed timing
        bus_grant = 1'b1;
        push(1'b1, 8'hA5);
        t0 = last_push;
        repeat (20) step();
        a = first_oe(t0, t0 + 20);
        s = rise_clk(t0, t0 + 20, 1);
        check("single_oe_rise", a - t0, 1);
        check("single_strobe_delay", s - a, 4);
        check("single_strobe_width", count_sig(t0, t0 + 20, 1), 2);
        check("single_strobe_data", h_bus[s], 8'hA5);
        check("single_strobe_cmd", h_cmd[s], 1);
        check("single_sent_pulses", count_sig(t0, t0 + 20, 2), 1);
        check("single_tx_count", tx_count, 1);
        check("single_oe_last", last_oe(t0, t0 + 20) - t0, 10);

        // Streaming four bytes
`ifdef MCU_BUS_TX_FIFO_EN
        bus_grant = 1'b0;
`endif
        c0 = tx_count;
        push(1'b0, 8'h01);
        t0 = last_push;
        push(1'b0, 8'h02);
        push(1'b0, 8'h03);
        push(1'b0, 8'h04);
`ifdef MCU_BUS_TX_FIFO_EN
        check("fifo_full_ready", tx_ready, 0);
        bus_grant = 1'b1;
`endif
        repeat (50) step();
        r1 = rise_clk(t0, t0 + 60, 1);
        r2 = rise_clk(t0, t0 + 60, 2);
        r3 = rise_clk(t0, t0 + 60, 3);
        r4 = rise_clk(t0, t0 + 60, 4);
        check("stream_gap12", r2 - r1, 6);
        check("stream_gap23", r3 - r2, 6);
        check("stream_gap34", r4 - r3, 6);
        check("stream_oe_held", count_sig(r1, r4, 0), r4 - r1 + 1);
        check("stream_count", tx_count, c0 + 16'd4);

        // Grant withheld
        bus_grant = 1'b0;
        c0 = tx_count;
        push(1'b0, 8'h55);
        t0 = last_push;
        repeat (50) step();
        check("withheld_oe", count_sig(t0, t0 + 49, 0), 0);
`ifndef MCU_BUS_TX_FIFO_EN
        tx_valid = 1'b1; tx_command = 1'b0; tx_data = 8'h66;
        for (int i = 0; i < 3; i++) begin
            check("refused_ready", tx_ready, 0);
            step();
        end
        tx_valid = 1'b0;
`endif
        bus_grant = 1'b1;
        wait_idle();
        check("withheld_count", tx_count, c0 + 16'd1);
        check("withheld_byte", bus_out, 8'h55);

        // Grant dropped during strobe with a second byte queued
        c0 = tx_count;
        push(1'b0, 8'h10);
        push(1'b0, 8'h11);
        wait_strobe();
        bus_grant = 1'b0;
        repeat (30) step();
        check("drop_count", tx_count, c0 + 16'd1);
        check("drop_byte", bus_out, 8'h10);
        check("drop_oe", bus_oe, 0);
        check("drop_queued_ready", tx_ready, (CAP > 1) ? 1 : 0);
        bus_grant = 1'b1;
        wait_idle();
        check("drop_resume_count", tx_count, c0 + 16'd2);
        check("drop_resume_byte", bus_out, 8'h11);

        // Reset during strobe
        push(1'b1, 8'h3C);
        wait_strobe();
        reset = 1'b1;
        step();
        check("rst_mid_oe", bus_oe, 0);
        check("rst_mid_clk", busclk_out, 0);
        check("rst_mid_count", tx_count, 0);
        check("rst_mid_ready", tx_ready, 1);
        reset = 1'b0;
        step();

        // Counter wrap
        force dut.tx_count = 16'hFFFF;
        m_count = 16'hFFFF;
        step();
        release dut.tx_count;
        step();
        check("wrap_preload", tx_count, 16'hFFFF);
        push(1'b0, 8'hE7);
        wait_idle();
        check("wrap_count", tx_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
